// File: rtl/pcm_highway_rx.sv
// Receive side of the 8-channel PCM highway: synchronizes bclk/frame_n/din, tracks bit
// position within the frame, deserializes channel slots and maintains frame lock.
module pcm_highway_rx #(
  parameter int unsigned FRAME_BITS  = 512,
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CH_PITCH    = 16,
  parameter int unsigned SLOT_BITS   = 8,
  parameter int unsigned FIRST_BIT   = 1,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned MISS_MAX    = 2
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic                      bclk,
  input  logic                      frame_n,
  input  logic                      din,
  output logic [SLOT_BITS-1:0]      ch_data,
  output logic [$clog2(NUM_CH)-1:0] ch_idx,
  output logic                      ch_valid,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam int unsigned CW = $clog2(NUM_CH);

  typedef logic [BW-1:0] pos_t;
  typedef logic [3:0]    cnt_t;

  localparam pos_t LastPos  = pos_t'(FRAME_BITS - 1);
  localparam pos_t FirstPos = pos_t'(FIRST_BIT);
  localparam pos_t Pitch    = pos_t'(CH_PITCH);
  localparam pos_t SlotLen  = pos_t'(SLOT_BITS);
  localparam pos_t NumCh    = pos_t'(NUM_CH);
  localparam cnt_t LockN    = cnt_t'(LOCK_FRAMES);
  localparam cnt_t MissN    = cnt_t'(MISS_MAX);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  logic [2:0]           bclk_sr;
  logic [1:0]           fn_sr;
  logic [1:0]           din_sr;
  logic                 fn_prev_q;
  pos_t                 bpos_q;
  logic [SLOT_BITS-2:0] shreg_q;
  state_e               state_q, state_d;
  cnt_t                 good_q, good_d;
  cnt_t                 miss_q, miss_d;
  logic                 sync_err_d;

  logic                 tick, fn_s, din_s, fstart, wrap, expected;
  pos_t                 bpos_nxt, off, slot, rem;
  logic                 in_slot, slot_last, emit;
  logic [SLOT_BITS-1:0] byte_nxt;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      bclk_sr <= '1;
      fn_sr   <= '1;
      din_sr  <= '0;
    end else begin
      bclk_sr <= {bclk_sr[1:0], bclk};
      fn_sr   <= {fn_sr[0], frame_n};
      din_sr  <= {din_sr[0], din};
    end
  end

  assign tick     = bclk_sr[1] & ~bclk_sr[2];
  assign fn_s     = fn_sr[1];
  assign din_s    = din_sr[1];
  assign fstart   = tick & ~fn_s & fn_prev_q;
  assign expected = (bpos_q == LastPos);
  assign wrap     = tick & ~fstart & expected;

  // Slot decode uses the position this tick's sample belongs to.
  always_comb begin
    bpos_nxt = '0;
    if (!fstart && !expected) bpos_nxt = bpos_q + 1'b1;
    off       = bpos_nxt - FirstPos;
    slot      = off / Pitch;
    rem       = off % Pitch;
    in_slot   = (bpos_nxt >= FirstPos) && (slot < NumCh) && (rem < SlotLen);
    slot_last = in_slot && (rem == SlotLen - 1'b1);
    byte_nxt  = {shreg_q, din_s};
    emit      = tick && !fstart && slot_last && (state_q == StLocked);
  end

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    miss_d     = miss_q;
    sync_err_d = 1'b0;
    if (fstart) begin
      case (state_q)
        StHunt: begin
          state_d = StVerify;
          good_d  = cnt_t'(1);
        end
        StVerify: begin
          if (expected) begin
            good_d = good_q + cnt_t'(1);
            if (good_q + cnt_t'(1) >= LockN) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else begin
            good_d = cnt_t'(1);
          end
        end
        StLocked: begin
          if (expected) begin
            miss_d = '0;
          end else begin
            sync_err_d = 1'b1;
            state_d    = StVerify;
            good_d     = cnt_t'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end else if (wrap) begin
      case (state_q)
        StVerify: state_d = StHunt;
        StLocked: begin
          if (miss_q + cnt_t'(1) >= MissN) begin
            state_d = StHunt;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + cnt_t'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q   <= StHunt;
      good_q    <= '0;
      miss_q    <= '0;
      fn_prev_q <= 1'b1;
      bpos_q    <= '0;
      shreg_q   <= '0;
      ch_data   <= '0;
      ch_idx    <= '0;
      ch_valid  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      sync_err <= sync_err_d;
      ch_valid <= emit;
      if (tick) begin
        fn_prev_q <= fn_s;
        bpos_q    <= bpos_nxt;
        // A frame start discards any partially assembled byte.
        if (fstart) shreg_q <= '0;
        else if (in_slot) shreg_q <= byte_nxt[SLOT_BITS-2:0];
      end
      if (emit) begin
        ch_data <= byte_nxt;
        ch_idx  <= slot[CW-1:0];
      end
    end
  end

  assign locked = (state_q == StLocked);

endmodule

// File: tb/tb_pcm_highway_rx.sv
// Directed bench for pcm_highway_rx: lock acquisition, slot capture, misplaced/missing
// frame starts, long frame_n, mid-slot reset and clk = 4x bclk operation.
`timescale 1ns/1ps
module tb_pcm_highway_rx;

  logic       clk = 1'b0;
  logic       rest = 1'b0;
  logic       bclk = 1'b0;
  logic       frame_n = 1'b1;
  logic       din = 1'b0;
  logic [7:0] ch_data;
  logic [2:0] ch_idx;
  logic       ch_valid;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int failures = 0;
  int sync_cnt = 0;

  logic [7:0] q_data[$];
  logic [2:0] q_idx[$];
  time        q_t[$];

  pcm_highway_rx dut (
    .clk     (clk),
    .rest    (rest),
    .bclk    (bclk),
    .frame_n (frame_n),
    .din     (din),
    .ch_data (ch_data),
    .ch_idx  (ch_idx),
    .ch_valid(ch_valid),
    .locked  (locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ch_valid) begin
      q_data.push_back(ch_data);
      q_idx.push_back(ch_idx);
      q_t.push_back($time);
    end
    if (sync_err) sync_cnt++;
  end

  function automatic logic bit_at(input int p, input logic [7:0] base);
    logic [7:0] b;
    int r;
    r = (p - 1) % 16;
    if (p >= 1 && p <= 120 && r < 8) begin
      b = 8'(base + (p - 1) / 16);
      return b[7-r];
    end
    return 1'b0;
  endfunction

  task automatic send_bit(input logic fn, input logic d);
    frame_n = fn;
    din = d;
    #20 bclk = 1'b1;
    #20 bclk = 1'b0;
  endtask

  // Positions first..last of a frame whose channel k byte is base+k.
  task automatic send_frame(input bit start, input int first, input int last, input int low_len,
                            input logic [7:0] base);
    for (int p = first; p <= last; p++) send_bit(!(start && p < low_len), bit_at(p, base));
    frame_n = 1'b1;
    din = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_idx.delete();
    q_t.delete();
  endtask

  task automatic test_reset();
    #23;
    checks++; if (ch_data !== 8'h00) begin failures++; $display("FAIL reset_ch_data: got %0h expected 0", ch_data); end
    checks++; if (ch_idx !== 3'd0) begin failures++; $display("FAIL reset_ch_idx: got %0d expected 0", ch_idx); end
    checks++; if (ch_valid !== 1'b0) begin failures++; $display("FAIL reset_ch_valid: got %b expected 0", ch_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    #7 rest = 1'b1;
    #30;
  endtask

  task automatic test_basic();
    clear_q();
    sync_cnt = 0;
    send_frame(1, 0, 511, 1, 8'hA0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL basic_f1_locked: got %b expected 0", locked); end
    checks++; if (q_data.size() != 0) begin failures++; $display("FAIL basic_f1_count: got %0d expected 0", q_data.size()); end
    send_frame(1, 0, 0, 1, 8'hA0);
    #30;
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL basic_f2_start_locked: got %b expected 1", locked); end
    send_frame(1, 1, 511, 1, 8'hA0);
    clear_q();
    send_frame(1, 0, 511, 1, 8'hA0);
    checks++;
    if (q_data.size() != 8) begin
      failures++; $display("FAIL basic_f3_count: got %0d expected 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_idx[k] !== 3'(k) || q_data[k] !== 8'(8'hA0 + k)) begin
          failures++; $display("FAIL basic_f3_byte%0d: got idx %0d data %0h expected idx %0d data %0h", k, q_idx[k], q_data[k], k, 8'(8'hA0 + k));
        end
        if (k > 0) begin
          checks++;
          if (q_t[k] - q_t[k-1] !== 640) begin
            failures++; $display("FAIL basic_f3_spacing%0d: got %0t expected 640", k, q_t[k] - q_t[k-1]);
          end
        end
      end
    end
    checks++; if (sync_cnt != 0) begin failures++; $display("FAIL basic_sync_err: got %0d expected 0", sync_cnt); end
  endtask

  task automatic test_misplaced();
    sync_cnt = 0;
    send_frame(1, 0, 299, 1, 8'hB0);
    clear_q();
    send_frame(1, 0, 511, 1, 8'hC0);
    checks++; if (sync_cnt != 1) begin failures++; $display("FAIL misplaced_sync_err: got %0d expected 1", sync_cnt); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL misplaced_locked: got %b expected 0", locked); end
    checks++; if (q_data.size() != 0) begin failures++; $display("FAIL misplaced_unlocked_count: got %0d expected 0", q_data.size()); end
    clear_q();
    send_frame(1, 0, 511, 1, 8'hD0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL misplaced_relock: got %b expected 1", locked); end
    checks++;
    if (q_data.size() != 8) begin
      failures++; $display("FAIL misplaced_count: got %0d expected 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_idx[k] !== 3'(k) || q_data[k] !== 8'(8'hD0 + k)) begin
          failures++; $display("FAIL misplaced_byte%0d: got idx %0d data %0h expected idx %0d data %0h", k, q_idx[k], q_data[k], k, 8'(8'hD0 + k));
        end
      end
    end
    checks++; if (sync_cnt != 1) begin failures++; $display("FAIL misplaced_sync_total: got %0d expected 1", sync_cnt); end
  endtask

  task automatic test_missing();
    clear_q();
    send_frame(0, 0, 511, 1, 8'h30);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL missing1_locked: got %b expected 1", locked); end
    checks++;
    if (q_data.size() != 8) begin
      failures++; $display("FAIL missing1_count: got %0d expected 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_idx[k] !== 3'(k) || q_data[k] !== 8'(8'h30 + k)) begin
          failures++; $display("FAIL missing1_byte%0d: got idx %0d data %0h expected idx %0d data %0h", k, q_idx[k], q_data[k], k, 8'(8'h30 + k));
        end
      end
    end
    send_frame(1, 0, 511, 1, 8'h40);
    send_frame(0, 0, 511, 1, 8'h50);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL missing2a_locked: got %b expected 1", locked); end
    clear_q();
    send_frame(0, 0, 511, 1, 8'h60);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL missing2b_locked: got %b expected 0", locked); end
    checks++; if (q_data.size() != 0) begin failures++; $display("FAIL missing2b_count: got %0d expected 0", q_data.size()); end
    send_frame(1, 0, 511, 1, 8'h70);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL missing_verify_locked: got %b expected 0", locked); end
    checks++; if (q_data.size() != 0) begin failures++; $display("FAIL missing_verify_count: got %0d expected 0", q_data.size()); end
    send_frame(1, 0, 511, 1, 8'h80);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL missing_relock: got %b expected 1", locked); end
    checks++; if (q_data.size() != 8) begin failures++; $display("FAIL missing_relock_count: got %0d expected 8", q_data.size()); end
  endtask

  task automatic test_long_frame_n();
    sync_cnt = 0;
    clear_q();
    send_frame(1, 0, 511, 5, 8'h90);
    checks++; if (sync_cnt != 0) begin failures++; $display("FAIL long_sync_err: got %0d expected 0", sync_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL long_locked: got %b expected 1", locked); end
    checks++;
    if (q_data.size() != 8) begin
      failures++; $display("FAIL long_count: got %0d expected 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_idx[k] !== 3'(k) || q_data[k] !== 8'(8'h90 + k)) begin
          failures++; $display("FAIL long_byte%0d: got idx %0d data %0h expected idx %0d data %0h", k, q_idx[k], q_data[k], k, 8'(8'h90 + k));
        end
      end
    end
    send_frame(1, 0, 511, 1, 8'h98);
    checks++; if (sync_cnt != 0 || locked !== 1'b1) begin failures++; $display("FAIL long_next_frame: got sync %0d locked %b expected sync 0 locked 1", sync_cnt, locked); end
  endtask

  task automatic test_reset_mid_slot();
    clear_q();
    send_frame(1, 0, 52, 1, 8'hE0);
    din = bit_at(53, 8'hE0);
    #10 rest = 1'b0;
    #1;
    checks++; if (ch_data !== 8'h00) begin failures++; $display("FAIL midrst_ch_data: got %0h expected 0", ch_data); end
    checks++; if (ch_idx !== 3'd0) begin failures++; $display("FAIL midrst_ch_idx: got %0d expected 0", ch_idx); end
    checks++; if (ch_valid !== 1'b0) begin failures++; $display("FAIL midrst_ch_valid: got %b expected 0", ch_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midrst_locked: got %b expected 0", locked); end
    checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL midrst_sync_err: got %b expected 0", sync_err); end
    #50;
    din = 1'b0;
    rest = 1'b1;
    #60;
    checks++; if (q_data.size() != 3) begin failures++; $display("FAIL midrst_no_ch3: got %0d expected 3", q_data.size()); end
    clear_q();
    send_frame(1, 0, 511, 1, 8'hF0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midrst_f1_locked: got %b expected 0", locked); end
    send_frame(1, 0, 511, 1, 8'hF8);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL midrst_relock: got %b expected 1", locked); end
    checks++;
    if (q_data.size() != 8) begin
      failures++; $display("FAIL midrst_count: got %0d expected 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_idx[k] !== 3'(k) || q_data[k] !== 8'(8'hF8 + k)) begin
          failures++; $display("FAIL midrst_byte%0d: got idx %0d data %0h expected idx %0d data %0h", k, q_idx[k], q_data[k], k, 8'(8'hF8 + k));
        end
      end
    end
  endtask

  task automatic test_ratio_edge();
    logic [7:0] base;
    sync_cnt = 0;
    #($urandom_range(1, 4));
    for (int f = 0; f < 10; f++) begin
      base = 8'(f * 16 + 3);
      clear_q();
      send_frame(1, 0, 511, 1, base);
      checks++;
      if (q_data.size() != 8) begin
        failures++; $display("FAIL ratio_f%0d_count: got %0d expected 8", f, q_data.size());
      end else begin
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (q_idx[k] !== 3'(k) || q_data[k] !== 8'(base + k)) begin
            failures++; $display("FAIL ratio_f%0d_byte%0d: got idx %0d data %0h expected idx %0d data %0h", f, k, q_idx[k], q_data[k], k, 8'(base + k));
          end
        end
      end
    end
    checks++; if (sync_cnt != 0) begin failures++; $display("FAIL ratio_sync_err: got %0d expected 0", sync_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ratio_locked: got %b expected 1", locked); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misplaced();
    test_missing();
    test_long_frame_n();
    test_reset_mid_slot();
    test_ratio_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
